// File: rtl/ones_count_seq.sv
// Sequential WIDTH-bit population count built around one shared 8-bit ones_count.
// Optional macro ONES_COUNT_SEQ_EARLY_EXIT_EN ends RUN as soon as the unshifted remainder is zero.

module ones_count (
  output logic [3:0] count,
  input  logic [7:0] dat_in
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      count = count + 4'(dat_in[i]);
    end
  end

endmodule

module ones_count_seq #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             busy
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic             out_valid_q, out_valid_d;

  logic [3:0]       byte_cnt;
  logic [CW-1:0]    sum;
  logic             last_byte;

  ones_count u_ones_count (
    .count  (byte_cnt),
    .dat_in (shreg_q[7:0])
  );

  assign sum = acc_q + CW'(byte_cnt);

`ifdef ONES_COUNT_SEQ_EARLY_EXIT_EN
  // Nothing left above the current byte: remaining RUN cycles would add zero.
  assign last_byte = (idx_q == IW'(NBYTES - 1)) || ((shreg_q >> 8) == '0);
`else
  assign last_byte = (idx_q == IW'(NBYTES - 1));
`endif

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = sum;
        shreg_d = shreg_q >> 8;
        idx_d   = idx_q + IW'(1);
        if (last_byte) begin
          out_count_d = sum;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_ones_count_seq.sv
// Randomised self-checking bench for ones_count_seq at WIDTH=32 and WIDTH=8,
// compared against a popcount/latency reference computed from the word itself.

module tb_ones_count_seq;

  localparam int W   = 32;
  localparam int CW  = 6;
  localparam int W8  = 8;
  localparam int CW8 = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;

  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data   = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_count;
  logic          busy;

  logic           in_valid8  = 1'b0;
  logic           in_ready8;
  logic [W8-1:0]  in_data8   = '0;
  logic           out_valid8;
  logic           out_ready8 = 1'b0;
  logic [CW8-1:0] out_count8;
  logic           busy8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ones_count_seq #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  ones_count_seq #(.WIDTH(W8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_data   (in_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_count (out_count8),
    .busy      (busy8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_count(input logic [31:0] d);
    return $countones(d);
  endfunction

  // Edges from accept to out_valid for a 4-byte word.
  function automatic int ref_lat(input logic [31:0] d);
`ifdef ONES_COUNT_SEQ_EARLY_EXIT_EN
    int lat = 1;
    logic [31:0] v = d;
    for (int b = 1; b < 4; b++) begin
      if (((v >> (8 * b)) & 32'hFF) != 0) lat = b + 1;
    end
    return lat;
`else
    return 4;
`endif
  endfunction

  // One word end to end; optionally presents the next word while this one sits in DONE.
  task automatic run_word(input logic [31:0] d, input int hold, input logic pre_next,
                          input logic [31:0] nxt);
    int n;
    int lat;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 64) begin
      check("busy_in_run", busy, 1);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, ref_lat(d));
    check("out_valid", out_valid, 1);
    check("out_count", out_count, ref_count(d));
    if (pre_next) begin
      in_valid = 1'b1;
      in_data  = nxt;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("done_valid_held", out_valid, 1);
      check("done_count_held", out_count, ref_count(d));
      check("done_not_ready", in_ready, 0);
      check("done_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_valid_low", out_valid, 0);
    check("handoff_ready", in_ready, 1);
    check("handoff_idle", busy, 0);
  endtask

  logic [31:0] words[$];

  initial begin
    #2 rst_n = 1'b0;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // out_ready with nothing pending must be ignored
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_out_ready_valid", out_valid, 0);
      check("idle_out_ready_rdy", in_ready, 1);
    end
    out_ready = 1'b0;

    run_word(32'hFFFF_FFFF, 0, 1'b0, '0);
    run_word(32'h8000_0001, 0, 1'b1, 32'h0F0F_00FF);
    run_word(32'h0F0F_00FF, 0, 1'b1, 32'h0000_0000);
    run_word(32'h0000_0000, 0, 1'b0, '0);
    run_word(32'h1234_5678, 5, 1'b1, 32'hA5A5_5A5A);
    run_word(32'hA5A5_5A5A, 0, 1'b0, '0);
    run_word(32'h0000_0003, 1, 1'b0, '0);
    run_word(32'h0100_0000, 0, 1'b0, '0);

    // abort during the second RUN cycle
    in_data  = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_run_valid", out_valid, 0);
    check("abort_run_count", out_count, 0);
    check("abort_run_ready", in_ready, 1);
    check("abort_run_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("abort_no_result", out_valid, 0);
    end
    run_word(32'h0000_00F0, 0, 1'b0, '0);

    // abort while a result is waiting in DONE
    in_data  = 32'h7F7F_7F7F;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 64 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    check("pre_abort_done_count", out_count, 28);
    #2 rst_n = 1'b0;
    #1;
    check("abort_done_valid", out_valid, 0);
    check("abort_done_count", out_count, 0);
    check("abort_done_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      logic [31:0] w;
      w = $urandom;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 1) == 0) w = w & ~(32'hFF << (8 * b));
      end
      words.push_back(w);
    end
    for (int i = 0; i < words.size(); i++) begin
      logic pre;
      pre = (i + 1 < words.size()) && ($urandom_range(0, 1) == 1);
      run_word(words[i], $urandom_range(0, 3), pre,
               (i + 1 < words.size()) ? words[i + 1] : 32'h0);
      if (!pre && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    // single-byte configuration: every value, one RUN cycle each
    for (int v = 0; v < 256; v++) begin
      in_data8  = 8'(v);
      in_valid8 = 1'b1;
      check("w8_ready", in_ready8, 1);
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      check("w8_busy", busy8, 1);
      @(posedge clk); #1;
      check("w8_valid", out_valid8, 1);
      check("w8_count", out_count8, $countones(v));
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      check("w8_handoff", out_valid8, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
